// File: rtl/pattern_serializer.sv
// Parallel-to-serial front end for the pattern-detector FSMs.
// Words arrive over a valid/ready handshake. Bits leave on d_o/valid_o, one
// per non-stalled cycle. A one-word holding buffer lets words stream back to back.
module pattern_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic             stall_i,
  output logic             d_o,
  output logic             valid_o,
  output logic             busy_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] hold;
  logic             hold_vld;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             load_edge;
  logic             src_vld;
  logic [WIDTH-1:0] src;

  // Bit that goes out first from a word, in the configured order.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Word with its first bit removed, so the next bit moves into first position.
  function automatic logic [WIDTH-1:0] drop_first(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Handshake status and selection of the next source word.
  always_comb begin
    wready_o  = ~hold_vld;
    busy_o    = valid_o | hold_vld;
    accept    = wvalid_i & ~hold_vld;
    load_edge = ~stall_i & ((state == IDLE) | (cnt == '0));
    // The held word is always older than data_i, so it takes priority.
    src_vld   = hold_vld | accept;
    src       = hold_vld ? hold : data_i;
  end

  // Shift engine, output registers and holding buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sreg     <= '0;
      hold     <= '0;
      hold_vld <= 1'b0;
      cnt      <= '0;
      d_o      <= 1'b0;
      valid_o  <= 1'b0;
    end else begin
      if (!stall_i) begin
        if (state == SHIFT && cnt != '0) begin
          d_o  <= first_bit(sreg);
          sreg <= drop_first(sreg);
          cnt  <= cnt - CW'(1);
        end else if (src_vld) begin
          d_o     <= first_bit(src);
          sreg    <= drop_first(src);
          cnt     <= CW'(WIDTH - 1);
          valid_o <= 1'b1;
          state   <= SHIFT;
        end else begin
          valid_o <= 1'b0;
          state   <= IDLE;
        end
      end
      // An accepted word goes to the buffer unless the shift engine loads it
      // directly on this edge; accept implies the buffer is empty.
      if (accept && !load_edge) begin
        hold     <= data_i;
        hold_vld <= 1'b1;
      end else if (load_edge && hold_vld) begin
        hold_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: an MSB-first and an LSB-first instance share
// the same stimulus and are compared each cycle against a queue-based model.
module tb_pattern_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] data = '0;
  logic         wvalid = 1'b0;
  logic         stall = 1'b0;
  logic         wready_m, d_m, valid_m, busy_m;
  logic         wready_l, d_l, valid_l, busy_l;

  pattern_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .data_i(data), .wvalid_i(wvalid), .wready_o(wready_m),
    .stall_i(stall), .d_o(d_m), .valid_o(valid_m), .busy_o(busy_m)
  );

  pattern_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .data_i(data), .wvalid_i(wvalid), .wready_o(wready_l),
    .stall_i(stall), .d_o(d_l), .valid_o(valid_l), .busy_o(busy_l)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending bits of the current word per bit order, a
  // one-word buffer, and the accepted/observed bitstreams (MSB-first instance).
  bit         m_valid, m_hold, m_d, m_dl;
  bit [W-1:0] m_holdw;
  bit         mq[$];
  bit         mql[$];
  bit         exp_stream[$];
  bit         obs_stream[$];
  int         run_len, max_run, valid_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_load(input bit [W-1:0] w);
    mq.delete();
    mql.delete();
    for (int i = W - 1; i >= 0; i--) mq.push_back(w[i]);
    for (int i = 0; i < W; i++) mql.push_back(w[i]);
    m_d     = mq.pop_front();
    m_dl    = mql.pop_front();
    m_valid = 1'b1;
  endtask

  task automatic model_reset();
    m_valid = 0; m_hold = 0; m_d = 0; m_dl = 0; m_holdw = '0;
    mq.delete(); mql.delete();
    exp_stream.delete(); obs_stream.delete();
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " valid_msb"}, 32'(valid_m), 32'(m_valid));
    chk({tag, " valid_lsb"}, 32'(valid_l), 32'(m_valid));
    chk({tag, " wready_msb"}, 32'(wready_m), 32'(!m_hold));
    chk({tag, " wready_lsb"}, 32'(wready_l), 32'(!m_hold));
    chk({tag, " busy"}, 32'(busy_m), 32'(m_valid | m_hold));
    chk({tag, " d_msb"}, 32'(d_m), 32'(m_d));
    chk({tag, " d_lsb"}, 32'(d_l), 32'(m_dl));
    if (valid_m === 1'b1) begin
      run_len++;
      valid_cnt++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, check at negedge.
  task automatic step(input bit wv, input bit [W-1:0] w, input bit st,
                      input string tag, output bit acc);
    wvalid = wv;
    data   = w;
    stall  = st;
    acc    = wv && !m_hold;
    if (valid_m === 1'b1 && !st) obs_stream.push_back(d_m);
    @(posedge clk);
    if (acc) for (int i = W - 1; i >= 0; i--) exp_stream.push_back(w[i]);
    if (!st) begin
      if (m_valid && mq.size() > 0) begin
        m_d  = mq.pop_front();
        m_dl = mql.pop_front();
        if (acc) begin m_hold = 1; m_holdw = w; end
      end else if (m_hold) begin
        model_load(m_holdw);
        m_hold = 0;
      end else if (acc) begin
        model_load(w);
      end else begin
        m_valid = 0;
      end
    end else if (acc) begin
      m_hold  = 1;
      m_holdw = w;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic tick(input bit wv, input bit [W-1:0] w, input bit st, input string tag);
    bit a;
    step(wv, w, st, tag, a);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(1'b0, W'($urandom), 1'b0, tag);
  endtask

  // Present a word until it is accepted, within a bounded number of cycles.
  task automatic send(input bit [W-1:0] w, input string tag);
    bit a = 0;
    int tries = 0;
    while (!a && tries < 50) begin
      step(1'b1, w, 1'b0, tag, a);
      tries++;
    end
    chk({tag, " accepted"}, 32'(a), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    int n;
    chk({tag, " stream length"}, 32'(obs_stream.size()), 32'(exp_stream.size()));
    n = (obs_stream.size() < exp_stream.size()) ? obs_stream.size() : exp_stream.size();
    for (int i = 0; i < n; i++) chk({tag, " stream bit"}, 32'(obs_stream[i]), 32'(exp_stream[i]));
    obs_stream.delete();
    exp_stream.delete();
  endtask

  function automatic int count_10110();
    int c = 0;
    for (int i = 4; i < obs_stream.size(); i++)
      if ({obs_stream[i-4], obs_stream[i-3], obs_stream[i-2], obs_stream[i-1], obs_stream[i]} == 5'b10110)
        c++;
    return c;
  endfunction

  // Asynchronous reset asserted mid-cycle; outputs must react without a clock.
  task automatic do_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    model_reset();
    wvalid = 0;
    stall  = 0;
    check_outputs({tag, " async"});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dets;
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(2, "post_reset");

    // Single word, both bit orders from the same stimulus.
    valid_cnt = 0;
    send(8'hB0, "t1");
    idle(10, "t1");
    chk("t1 valid cycles", 32'(valid_cnt), 32'd8);
    valid_cnt = 0;
    send(8'h0D, "t2");
    idle(10, "t2");
    chk("t2 valid cycles", 32'(valid_cnt), 32'd8);
    check_stream("t12");

    // Back-to-back words with wvalid held high.
    max_run = 0;
    run_len = 0;
    send(8'h16, "t3");
    send(8'hB5, "t3");
    send(8'hFF, "t3");
    idle(25, "t3");
    chk("t3 continuous run", 32'(max_run), 32'd24);
    check_stream("t3");

    // Three-cycle stall after the third bit.
    valid_cnt = 0;
    send(8'hB4, "t4");
    tick(1'b0, 8'h00, 1'b0, "t4");
    tick(1'b0, 8'h00, 1'b0, "t4");
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1, "t4 stall");
    idle(12, "t4");
    chk("t4 valid cycles", 32'(valid_cnt), 32'd11);
    check_stream("t4");

    // Accept while stalled in IDLE goes through the buffer.
    tick(1'b1, 8'hA5, 1'b1, "t5 accept_stalled");
    tick(1'b1, 8'h3C, 1'b1, "t5 hold_full");
    tick(1'b0, 8'h00, 1'b0, "t5 release");
    idle(10, "t5");
    check_stream("t5");

    // Randomized traffic with stalls.
    for (int i = 0; i < 400; i++)
      tick(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 4) == 0), "rand");
    idle(20, "rand_drain");
    check_stream("rand");

    // Reset during the fourth bit, then a clean word feeding the 10110 detector.
    send(8'h9C, "t6");
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, "t6");
    do_reset("t6 reset");
    idle(2, "t6 post_reset");
    send(8'hB6, "t6");
    idle(10, "t6");
    dets = count_10110();
    chk("t6 10110 detections", 32'(dets), 32'd2);
    check_stream("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
